if_fetch_buf: RTL and testbench

Parametrised instruction-fetch stage for the LoongArch pipeline. It replaces the single-cycle SRAM fetch with a split request/response SRAM-like interface that allows multiple outstanding fetches. Returned instructions go into an instruction buffer of configurable depth that decouples fetch from ID stalls. On branch redirect it flushes the buffer and discards in-flight responses. It sits between the instruction SRAM bridge and ID, and drives the same `{pc, inst}` bus to ID.

---
 rtl/if_fetch_buf.sv | 196 +++++++++++++++++++
 tb/tb_if_fetch_buf.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_buf.sv
// rtl/if_fetch_buf.sv - LoongArch IF stage: split-transaction fetch feeding an instruction buffer
// Optional misaligned-target (ADEF) entry generation when IF_ADEF_CHECK_EN is defined.
module if_fetch_buf #(
  parameter logic [31:0] RESET_PC   = 32'h1c000000,
  parameter int          IBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [32:0] br_bus,
  input  logic        ID_Allow_in,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        IF_to_ID_Valid,
  output logic [63:0] IF_to_ID_Bus
`ifdef IF_ADEF_CHECK_EN
  ,
  output logic        if_adef
`endif
);
  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = PW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(IBUF_DEPTH);

  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] fpc_q, fpc_d, redir_pc_q, redir_pc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [PW:0] cancel_q, cancel_d;
  logic [31:0] tag_mem_q [IBUF_DEPTH];
  logic [31:0] tag_mem_d [IBUF_DEPTH];
  logic [PW-1:0] tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [PW:0] tag_cnt_q, tag_cnt_d;
  logic [63:0] buf_mem_q [IBUF_DEPTH];
  logic [63:0] buf_mem_d [IBUF_DEPTH];
  logic [PW-1:0] buf_wp_q, buf_wp_d, buf_rp_q, buf_rp_d;
  logic [PW:0] buf_cnt_q, buf_cnt_d;
  logic [CW-1:0] credits;
  logic        accept, rsp_ok, head_pop, fetch_hold;
  logic        tag_push, tag_pop, buf_push;

  assign br_taken = br_bus[32];
`ifdef IF_ADEF_CHECK_EN
  logic adef_mem_q [IBUF_DEPTH];
  logic adef_mem_d [IBUF_DEPTH];
  logic stall_q, stall_d;
  assign br_target  = br_bus[31:0];
  assign fetch_hold = stall_q;
  assign if_adef    = IF_to_ID_Valid && adef_mem_q[buf_rp_q];
`else
  logic unused_br_lsb;
  assign unused_br_lsb = ^br_bus[1:0];
  assign br_target  = {br_bus[31:2], 2'b00};
  assign fetch_hold = 1'b0;
`endif

  // Every issued request already owns a buffer slot, so responses never overflow the buffer.
  assign credits        = CW'(buf_cnt_q) + CW'(tag_cnt_q) + CW'(cancel_q);
  assign inst_req       = !reset && !fetch_hold && (credits < DEPTH_C);
  assign inst_addr      = fpc_q;
  assign accept         = inst_req && inst_addr_ok;
  assign rsp_ok         = inst_data_ok && ((tag_cnt_q != '0) || (cancel_q != '0));
  assign IF_to_ID_Valid = (buf_cnt_q != '0);
  assign IF_to_ID_Bus   = IF_to_ID_Valid ? buf_mem_q[buf_rp_q] : 64'h0;
  assign head_pop       = IF_to_ID_Valid && ID_Allow_in && !br_taken;

  always_comb begin
    fpc_d        = fpc_q;
    redir_pc_d   = redir_pc_q;
    redir_pend_d = redir_pend_q;
    cancel_d     = cancel_q;
    tag_mem_d    = tag_mem_q;
    tag_wp_d     = tag_wp_q;
    tag_rp_d     = tag_rp_q;
    tag_cnt_d    = tag_cnt_q;
    buf_mem_d    = buf_mem_q;
    buf_wp_d     = buf_wp_q;
    buf_rp_d     = buf_rp_q;
    buf_cnt_d    = buf_cnt_q;
    tag_push     = 1'b0;
    tag_pop      = 1'b0;
    buf_push     = 1'b0;
`ifdef IF_ADEF_CHECK_EN
    adef_mem_d   = adef_mem_q;
    stall_d      = stall_q;
`endif
    if (br_taken) begin
      tag_wp_d  = '0;
      tag_rp_d  = '0;
      tag_cnt_d = '0;
      buf_wp_d  = '0;
      buf_rp_d  = '0;
      buf_cnt_d = '0;
      // Everything still owed by the bridge, including this cycle's accept, becomes a discard.
      cancel_d  = (PW+1)'(CW'(tag_cnt_q) + CW'(cancel_q) + CW'(accept) - CW'(rsp_ok));
      if (accept || !inst_req) begin
        fpc_d        = br_target;
        redir_pend_d = 1'b0;
      end else begin
        redir_pc_d   = br_target;
        redir_pend_d = 1'b1;
      end
`ifdef IF_ADEF_CHECK_EN
      stall_d = 1'b0;
      if ((accept || !inst_req) && (br_target[1:0] != 2'b00)) begin
        buf_mem_d[0]  = {br_target, 32'h0};
        adef_mem_d[0] = 1'b1;
        buf_wp_d      = PW'(1);
        buf_cnt_d     = (PW+1)'(1);
        stall_d       = 1'b1;
      end
`endif
    end else begin
      if (rsp_ok) begin
        if (cancel_q != '0) begin
          cancel_d = cancel_q - 1'b1;
        end else begin
          tag_pop             = 1'b1;
          buf_push            = 1'b1;
          buf_mem_d[buf_wp_q] = {tag_mem_q[tag_rp_q], inst_rdata};
`ifdef IF_ADEF_CHECK_EN
          adef_mem_d[buf_wp_q] = 1'b0;
`endif
        end
      end
      if (accept) begin
        if (redir_pend_q) begin
          // The held old-path request is finally out; its answer is dropped.
          cancel_d     = cancel_d + 1'b1;
          fpc_d        = redir_pc_q;
          redir_pend_d = 1'b0;
`ifdef IF_ADEF_CHECK_EN
          if (redir_pc_q[1:0] != 2'b00) begin
            buf_push             = 1'b1;
            buf_mem_d[buf_wp_q]  = {redir_pc_q, 32'h0};
            adef_mem_d[buf_wp_q] = 1'b1;
            stall_d              = 1'b1;
          end
`endif
        end else begin
          tag_push            = 1'b1;
          tag_mem_d[tag_wp_q] = fpc_q;
          fpc_d               = fpc_q + 32'd4;
        end
      end
      tag_wp_d  = tag_wp_q + PW'(tag_push);
      tag_rp_d  = tag_rp_q + PW'(tag_pop);
      tag_cnt_d = tag_cnt_q + (PW+1)'(tag_push) - (PW+1)'(tag_pop);
      buf_wp_d  = buf_wp_q + PW'(buf_push);
      buf_rp_d  = buf_rp_q + PW'(head_pop);
      buf_cnt_d = buf_cnt_q + (PW+1)'(buf_push) - (PW+1)'(head_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q        <= RESET_PC;
      redir_pc_q   <= RESET_PC;
      redir_pend_q <= 1'b0;
      cancel_q     <= '0;
      tag_wp_q     <= '0;
      tag_rp_q     <= '0;
      tag_cnt_q    <= '0;
      buf_wp_q     <= '0;
      buf_rp_q     <= '0;
      buf_cnt_q    <= '0;
`ifdef IF_ADEF_CHECK_EN
      stall_q      <= 1'b0;
`endif
    end else begin
      fpc_q        <= fpc_d;
      redir_pc_q   <= redir_pc_d;
      redir_pend_q <= redir_pend_d;
      cancel_q     <= cancel_d;
      tag_wp_q     <= tag_wp_d;
      tag_rp_q     <= tag_rp_d;
      tag_cnt_q    <= tag_cnt_d;
      buf_wp_q     <= buf_wp_d;
      buf_rp_q     <= buf_rp_d;
      buf_cnt_q    <= buf_cnt_d;
`ifdef IF_ADEF_CHECK_EN
      stall_q      <= stall_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    tag_mem_q <= tag_mem_d;
    buf_mem_q <= buf_mem_d;
`ifdef IF_ADEF_CHECK_EN
    adef_mem_q <= adef_mem_d;
`endif
  end
endmodule

// File: tb/tb_if_fetch_buf.sv
// tb/tb_if_fetch_buf.sv - self-checking bench for if_fetch_buf
// Bridge model with in-order responses plus a fetch-stream reference model.
module tb_if_fetch_buf;
  localparam logic [31:0] P = 32'h1c000000;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [32:0] br_bus;
  logic        ID_Allow_in, inst_req, inst_addr_ok, inst_data_ok, IF_to_ID_Valid;
  logic [31:0] inst_addr, inst_rdata;
  logic [63:0] IF_to_ID_Bus;
`ifdef IF_ADEF_CHECK_EN
  logic        if_adef;
`endif

  always #5 clk = ~clk;

  if_fetch_buf #(.RESET_PC(P), .IBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .br_bus(br_bus), .ID_Allow_in(ID_Allow_in),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .IF_to_ID_Valid(IF_to_ID_Valid), .IF_to_ID_Bus(IF_to_ID_Bus)
`ifdef IF_ADEF_CHECK_EN
    , .if_adef(if_adef)
`endif
  );

  int errors = 0, checks = 0, cyc = 0, lat = 1, pops = 0;
  bit lat_rand = 0, model_on = 1;
  logic [31:0] q_addr[$];
  int          q_rdy[$];
  logic [31:0] m_addr, m_tgt, exp_pc, held_addr;
  bit          m_pend, held_prev;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a3c3c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q_addr.delete(); q_rdy.delete();
    m_addr = P; exp_pc = P; m_pend = 0; held_prev = 0;
  endtask

  task automatic set_inputs(input bit rst_i, input bit allow_i, input bit aok_i,
                            input bit br_i, input logic [31:0] tgt_i, input int dprob);
    reset = rst_i; ID_Allow_in = allow_i; inst_addr_ok = aok_i; br_bus = {br_i, tgt_i};
    if (!rst_i && q_addr.size() > 0 && q_rdy[0] <= cyc && int'($urandom_range(99)) < dprob) begin
      inst_data_ok = 1'b1; inst_rdata = mem_fn(q_addr[0]);
    end else begin
      inst_data_ok = 1'b0; inst_rdata = $urandom;
    end
    #1;
  endtask

  // Reference: the ID stream is consecutive words from the last redirect target; the
  // request stream is consecutive words, switching to the target once no request is held.
  task automatic model_step();
    logic [31:0] tgt;
    bit acc, br;
    if (reset) begin
      model_reset();
      return;
    end
    br  = br_bus[32];
    tgt = br_bus[31:0] & ~32'h3;
    acc = inst_req && inst_addr_ok;
    if (model_on) begin
      if (held_prev) begin
        chk("req_hold", 64'(inst_req), 64'd1);
        chk("addr_hold", 64'(inst_addr), 64'(held_addr));
      end
      if (inst_req) chk("req_addr", 64'(inst_addr), 64'(m_addr));
      chk("outstanding_bound", 64'(q_addr.size() <= DEPTH), 64'd1);
      if (IF_to_ID_Valid && ID_Allow_in && !br) begin
        chk("id_pc", 64'(IF_to_ID_Bus[63:32]), 64'(exp_pc));
        chk("id_inst", 64'(IF_to_ID_Bus[31:0]), 64'(mem_fn(exp_pc)));
        exp_pc = exp_pc + 4;
        pops++;
      end
    end
    if (inst_data_ok) begin
      void'(q_addr.pop_front()); void'(q_rdy.pop_front());
    end
    if (acc) begin
      q_addr.push_back(inst_addr);
      q_rdy.push_back(cyc + (lat_rand ? int'($urandom_range(4, 1)) : lat));
    end
    if (br) begin
      exp_pc = tgt;
      if (acc || !inst_req) begin m_addr = tgt; m_pend = 0; end
      else begin m_tgt = tgt; m_pend = 1; end
    end else if (acc) begin
      m_addr = m_pend ? m_tgt : m_addr + 4;
      m_pend = 0;
    end
    held_prev = inst_req && !inst_addr_ok;
    held_addr = inst_addr;
  endtask

  task automatic finish_cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    set_inputs(1, 0, 0, 0, 32'h0, 0); finish_cycle();
    set_inputs(1, 0, 0, 0, 32'h0, 0); finish_cycle();
  endtask

  task automatic wait_first(input string nm, input logic [31:0] pc_e, input int rel_e, input int c0);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      set_inputs(0, 1, 1, 0, 32'h0, 100);
      if (IF_to_ID_Valid) begin
        found = 1;
        chk({nm, "_first_pc"}, 64'(IF_to_ID_Bus[63:32]), 64'(pc_e));
        chk({nm, "_first_cycle"}, 64'(cyc - c0), 64'(rel_e));
      end
      finish_cycle();
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no valid entry within 40 cycles", nm);
    end
  endtask

  typedef struct {
    bit chk_en; bit rst; bit allow; bit aok;
    bit exp_req; logic [31:0] exp_addr; bit exp_valid; logic [31:0] exp_pc;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(input bit c, input bit r, input bit a, input bit k,
                              input bit rq, input logic [31:0] ad, input bit v, input logic [31:0] pc);
    vec_t t;
    t.chk_en = c; t.rst = r; t.allow = a; t.aok = k;
    t.exp_req = rq; t.exp_addr = ad; t.exp_valid = v; t.exp_pc = pc;
    return t;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    bit br, prev_br;
    logic [31:0] tgt;
    // Streaming with 1-cycle latency, then the full-buffer backpressure case.
    tv.push_back(mk(1, 1, 1, 1, 0, P,      0, 0));
    tv.push_back(mk(1, 0, 1, 1, 1, P,      0, 0));
    tv.push_back(mk(1, 0, 1, 1, 1, P + 4,  0, 0));
    tv.push_back(mk(1, 0, 1, 1, 1, P + 8,  1, P));
    tv.push_back(mk(1, 0, 1, 1, 1, P + 12, 1, P + 4));
    tv.push_back(mk(1, 0, 1, 1, 1, P + 16, 1, P + 8));
    tv.push_back(mk(0, 1, 0, 0, 0, P,      0, 0));
    tv.push_back(mk(1, 1, 0, 0, 0, P,      0, 0));
    tv.push_back(mk(1, 0, 0, 1, 1, P,      0, 0));
    tv.push_back(mk(1, 0, 0, 1, 1, P + 4,  0, 0));
    tv.push_back(mk(1, 0, 0, 1, 1, P + 8,  1, P));
    tv.push_back(mk(1, 0, 0, 1, 1, P + 12, 1, P));
    tv.push_back(mk(1, 0, 0, 1, 0, P + 16, 1, P));
    tv.push_back(mk(1, 0, 0, 1, 0, P + 16, 1, P));
    tv.push_back(mk(1, 0, 1, 1, 0, P + 16, 1, P));
    tv.push_back(mk(1, 0, 0, 1, 1, P + 16, 1, P + 4));
    tv.push_back(mk(1, 0, 0, 1, 0, P + 20, 1, P + 4));
    tv.push_back(mk(1, 0, 0, 1, 0, P + 20, 1, P + 4));

    model_reset();
    set_inputs(1, 0, 0, 0, 32'h0, 0); finish_cycle();
    lat = 1;
    for (int i = 0; i < tv.size(); i++) begin
      set_inputs(tv[i].rst, tv[i].allow, tv[i].aok, 0, 32'h0, 100);
      if (tv[i].chk_en) begin
        chk($sformatf("tv%0d_req", i), 64'(inst_req), 64'(tv[i].exp_req));
        chk($sformatf("tv%0d_addr", i), 64'(inst_addr), 64'(tv[i].exp_addr));
        chk($sformatf("tv%0d_valid", i), 64'(IF_to_ID_Valid), 64'(tv[i].exp_valid));
        if (tv[i].exp_valid) chk($sformatf("tv%0d_pc", i), 64'(IF_to_ID_Bus[63:32]), 64'(tv[i].exp_pc));
        if (tv[i].rst) chk($sformatf("tv%0d_bus", i), IF_to_ID_Bus, 64'h0);
      end
      finish_cycle();
    end

    // Three requests in flight with 5-cycle latency, redirect alongside the third accept.
    do_reset(); lat = 5; c0 = cyc;
    set_inputs(0, 1, 1, 0, 32'h0, 100); finish_cycle();
    set_inputs(0, 1, 1, 0, 32'h0, 100); finish_cycle();
    set_inputs(0, 1, 1, 1, 32'h1c000100, 100); finish_cycle();
    wait_first("stale", 32'h1c000100, 9, c0);

    // Redirect while the request is held unaccepted.
    do_reset(); lat = 1; c0 = cyc;
    set_inputs(0, 1, 0, 0, 32'h0, 100);
    chk("held_req", 64'(inst_req), 64'd1);
    finish_cycle();
    set_inputs(0, 1, 0, 1, 32'h1c000200, 100); finish_cycle();
    for (int i = 0; i < 2; i++) begin
      set_inputs(0, 1, 0, 0, 32'h0, 100);
      chk("held_addr_stable", 64'(inst_addr), 64'(P));
      finish_cycle();
    end
    set_inputs(0, 1, 1, 0, 32'h0, 100); finish_cycle();
    set_inputs(0, 1, 1, 0, 32'h0, 100);
    chk("held_next_addr", 64'(inst_addr), 64'h1c000200);
    finish_cycle();
    wait_first("held", 32'h1c000200, 7, c0);

`ifdef IF_ADEF_CHECK_EN
    do_reset(); model_on = 0;
    set_inputs(0, 0, 1, 1, 32'h1c000102, 100); finish_cycle();
    set_inputs(0, 0, 1, 0, 32'h0, 100);
    chk("adef_valid", 64'(IF_to_ID_Valid), 64'd1);
    chk("adef_bus", IF_to_ID_Bus, {32'h1c000102, 32'h0});
    chk("adef_flag", 64'(if_adef), 64'd1);
    finish_cycle();
    for (int i = 0; i < 3; i++) begin
      set_inputs(0, 0, 1, 0, 32'h0, 100);
      chk("adef_stall_req", 64'(inst_req), 64'd0);
      finish_cycle();
    end
    model_on = 1;
`else
    do_reset(); lat = 1; c0 = cyc;
    set_inputs(0, 1, 1, 1, 32'h1c000106, 100); finish_cycle();
    set_inputs(0, 1, 1, 0, 32'h0, 100);
    chk("align_addr", 64'(inst_addr), 64'h1c000104);
    finish_cycle();
    wait_first("align", 32'h1c000104, 3, c0);
`endif

    // Full buffer, then simultaneous push/pop with random response gaps.
    do_reset(); lat = 1;
    for (int i = 0; i < 8; i++) begin
      set_inputs(0, 0, 1, 0, 32'h0, 100); finish_cycle();
    end
    set_inputs(0, 0, 1, 0, 32'h0, 100);
    chk("full_req", 64'(inst_req), 64'd0);
    chk("full_valid", 64'(IF_to_ID_Valid), 64'd1);
    finish_cycle();
    for (int i = 0; i < 20; i++) begin
      set_inputs(0, 1, 1, 0, 32'h0, 60); finish_cycle();
    end

    // Random traffic with redirects and random latency.
    lat_rand = 1; pops = 0; prev_br = 0;
    for (int k = 0; k < 400; k++) begin
      br  = !prev_br && ($urandom_range(99) < 4);
      tgt = 32'h1c010000 + ($urandom_range(1023) << 2);
      set_inputs(0, $urandom_range(99) < 70, $urandom_range(99) < 75, br, tgt, 70);
      finish_cycle();
      prev_br = br;
    end
    chk("random_progress", 64'(pops >= 20), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
